// File: rtl/uart_cmd_wrapper.sv
// Frames the UART byte stream into 3-byte {cmd, data_hi, data_lo} commands with an
// inter-byte timeout, and returns 1-byte responses through a 1-deep pending buffer.
module uart_cmd_wrapper #(
  parameter int unsigned TMO_CYCLES = 1_000_000,
  parameter int unsigned TMO_W      = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        frm_err
);

  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} rx_state_e;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  rx_state_e         rx_state_q, rx_state_d;
  logic [7:0]        cmd_shd_q, cmd_shd_d;
  logic [7:0]        hi_shd_q, hi_shd_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [15:0]       data_q, data_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              tmo_expired;

  tx_state_e         tx_state_q, tx_state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        pend_byte_q, pend_byte_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              trmt_q, trmt_d;

  // A byte present in the expiry cycle takes priority over the timeout.
  assign tmo_expired = (rx_state_q != WAIT_CMD) && (tmo_cnt_q == TMO_LAST) && !rx_rdy;

  always_comb begin
    rx_state_d = rx_state_q;
    cmd_shd_d  = cmd_shd_q;
    hi_shd_d   = hi_shd_q;
    tmo_cnt_d  = tmo_cnt_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    cmd_rdy_d  = cmd_rdy_q;
    clr_rx_rdy = rx_rdy;
    frm_err    = 1'b0;

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    case (rx_state_q)
      WAIT_CMD: begin
        tmo_cnt_d = '0;
        if (rx_rdy) begin
          cmd_shd_d  = rx_data;
          cmd_rdy_d  = 1'b0;
          rx_state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_shd_d   = rx_data;
          tmo_cnt_d  = '0;
          rx_state_d = WAIT_LO;
        end else if (tmo_expired) begin
          frm_err    = 1'b1;
          cmd_shd_d  = '0;
          hi_shd_d   = '0;
          tmo_cnt_d  = '0;
          rx_state_d = WAIT_CMD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cmd_d      = cmd_shd_q;
          data_d     = {hi_shd_q, rx_data};
          cmd_rdy_d  = 1'b1;
          tmo_cnt_d  = '0;
          rx_state_d = WAIT_CMD;
        end else if (tmo_expired) begin
          frm_err    = 1'b1;
          cmd_shd_d  = '0;
          hi_shd_d   = '0;
          tmo_cnt_d  = '0;
          rx_state_d = WAIT_CMD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        tmo_cnt_d  = '0;
        rx_state_d = WAIT_CMD;
      end
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    pend_vld_d  = pend_vld_q;
    pend_byte_d = pend_byte_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;

    if (tx_state_q == TX_IDLE) begin
      // A held byte launches first; a request arriving alongside it becomes the new pending byte.
      if (pend_vld_q) begin
        tx_data_d  = pend_byte_q;
        trmt_d     = 1'b1;
        tx_state_d = TX_BUSY;
        pend_vld_d = send_resp;
        if (send_resp) begin
          pend_byte_d = resp;
        end
      end else if (send_resp) begin
        tx_data_d  = resp;
        trmt_d     = 1'b1;
        tx_state_d = TX_BUSY;
      end
    end else begin
      if (send_resp) begin
        pend_byte_d = resp;
        pend_vld_d  = 1'b1;
      end
      if (tx_done) begin
        tx_state_d = TX_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= WAIT_CMD;
      cmd_shd_q   <= '0;
      hi_shd_q    <= '0;
      tmo_cnt_q   <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_rdy_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      pend_vld_q  <= 1'b0;
      pend_byte_q <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      cmd_shd_q   <= cmd_shd_d;
      hi_shd_q    <= hi_shd_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_state_q  <= tx_state_d;
      pend_vld_q  <= pend_vld_d;
      pend_byte_q <= pend_byte_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
    end
  end

  assign cmd_rdy = cmd_rdy_q;
  assign cmd     = cmd_q;
  assign data    = data_q;
  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;

endmodule
